bus_hs_skid_pipe: RTL and testbench

//   Parametrised valid/ready pipeline for the point-to-point source->destination bus.

---
 rtl/bus_hs_pkg.sv | 12 +
 rtl/bus_hs_skid_stage.sv | 76 +++++++
 rtl/bus_hs_skid_pipe.sv | 96 +++++++++
 tb/tb_bus_hs_skid_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_hs_pkg.sv
// Shared constants and helpers for the valid/ready skid pipeline.
package bus_hs_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  // Bits needed to count 0..2*stages held beats
  function automatic int unsigned clog2_lvl(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/bus_hs_skid_stage.sv
// One full-throughput skid slice: main + skid register, all outputs from flops.
module bus_hs_skid_stage
  import bus_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        lvl_o
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              ready_q, ready_d;
  logic [1:0]        lvl_q, lvl_d;
  logic              in_fire_c;

  // ready_q is low in reset and tracks !skid_full afterwards, so it never
  // accepts while the skid is occupied.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    in_fire_c    = in_valid_i & ready_q;

    if (!main_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire_c;
        if (in_fire_c) main_data_d = in_data_i;
      end
    end else if (in_fire_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end

    ready_d = !skid_valid_d;
    lvl_d   = 2'(main_valid_d) + 2'(skid_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
      lvl_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
      lvl_q        <= lvl_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign lvl_o       = lvl_q;

endmodule

// File: rtl/bus_hs_skid_pipe.sv
// Cascade of skid slices with occupancy level and transfer/stall counters.
module bus_hs_skid_pipe
  import bus_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid_i,
  input  logic [DATA_W-1:0]             s_data_i,
  output logic                          s_ready_o,
  output logic                          m_valid_o,
  output logic [DATA_W-1:0]             m_data_o,
  input  logic                          m_ready_i,
  input  logic                          clr_cnt_i,
  output logic [clog2_lvl(STAGES)-1:0]  level_o,
  output logic [CNT_W-1:0]              xfer_cnt_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  localparam int unsigned LVL_W = clog2_lvl(STAGES);

  logic              vld [STAGES+1];
  logic              rdy [STAGES+1];
  logic [DATA_W-1:0] dat [STAGES+1];
  logic [1:0]        lvl [STAGES];

  assign vld[0]      = s_valid_i;
  assign dat[0]      = s_data_i;
  assign rdy[STAGES] = m_ready_i;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    bus_hs_skid_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (vld[g]),
      .in_data_i   (dat[g]),
      .in_ready_o  (rdy[g]),
      .out_valid_o (vld[g+1]),
      .out_data_o  (dat[g+1]),
      .out_ready_i (rdy[g+1]),
      .lvl_o       (lvl[g])
    );
  end

  assign s_ready_o = rdy[0];
  assign m_valid_o = vld[STAGES];
  assign m_data_o  = dat[STAGES];

  // Occupancy is the sum of per-slice registered counts
  always_comb begin
    level_o = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      level_o = level_o + LVL_W'(lvl[i]);
    end
  end

  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             m_fire_c, m_stall_c;

  // Clear wins over increment; transfers wrap, stalls saturate
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    m_fire_c    = m_valid_o & m_ready_i;
    m_stall_c   = m_valid_o & !m_ready_i;
    if (clr_cnt_i) begin
      xfer_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (m_fire_c) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      if (m_stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt_o  = xfer_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_bus_hs_skid_pipe.sv
// Directed and random checks of bus_hs_skid_pipe with a scoreboard monitor.
module tb_bus_hs_skid_pipe;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LVL_W  = 3;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              s_valid_i = 1'b0;
  logic [DATA_W-1:0] s_data_i  = '0;
  logic              s_ready_o;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ready_i = 1'b0;
  logic              clr_cnt_i = 1'b0;
  logic [LVL_W-1:0]  level_o;
  logic [CNT_W-1:0]  xfer_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb_q [$];
  logic [CNT_W-1:0]  exp_xfer  = '0;
  logic [CNT_W-1:0]  exp_stall = '0;
  logic              prev_hold = 1'b0;

  bus_hs_skid_pipe #(
    .DATA_W (DATA_W),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_ready_i   (m_ready_i),
    .clr_cnt_i   (clr_cnt_i),
    .level_o     (level_o),
    .xfer_cnt_o  (xfer_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded)
  task automatic send(input logic [DATA_W-1:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    do begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    chk("send_accept", 32'(acc), 32'(1));
    s_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready_i = 1'b1;
    s_valid_i = 1'b0;
    while (level_o != '0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_level", 32'(level_o), 32'(0));
    chk("drain_sb", 32'(sb_q.size()), 32'(0));
  endtask

  // Scoreboard monitor: checks state mid-cycle, then predicts the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_xfer  = '0;
      exp_stall = '0;
      prev_hold = 1'b0;
    end else begin
      chk("level", 32'(level_o), 32'(sb_q.size()));
      chk("xfer_cnt", 32'(xfer_cnt_o), 32'(exp_xfer));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));
      if (prev_hold) chk("valid_held", 32'(m_valid_o), 32'(1));
      if (m_valid_o) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=0x%0h expected=none", m_data_o);
        end
        if (sb_q.size() != 0) chk("m_data", 32'(m_data_o), 32'(sb_q[0]));
      end
      if (sb_q.size() == 2 * STAGES) chk("full_ready", 32'(s_ready_o), 32'(0));
      if (sb_q.size() == 0) chk("empty_valid", 32'(m_valid_o), 32'(0));

      if (m_valid_o && m_ready_i && sb_q.size() != 0) void'(sb_q.pop_front());
      if (s_valid_i && s_ready_o) sb_q.push_back(s_data_i);

      if (clr_cnt_i) begin
        exp_xfer  = '0;
        exp_stall = '0;
      end else begin
        if (m_valid_o && m_ready_i) exp_xfer = exp_xfer + CNT_W'(1);
        if (m_valid_o && !m_ready_i && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + CNT_W'(1);
      end
      prev_hold = m_valid_o && !m_ready_i;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic acc;
  int   idx;
  int   n;
  int   cyc;

  initial begin
    // 1: reset with valid asserted
    rst_n = 1'b0; s_valid_i = 1'b1; s_data_i = 8'h99; m_ready_i = 1'b1;
    repeat (3) step();
    chk("rst_m_valid", 32'(m_valid_o), 32'(0));
    chk("rst_s_ready", 32'(s_ready_o), 32'(0));
    chk("rst_level", 32'(level_o), 32'(0));
    chk("rst_m_data", 32'(m_data_o), 32'(0));
    chk("rst_xfer", 32'(xfer_cnt_o), 32'(0));
    chk("rst_stall", 32'(stall_cnt_o), 32'(0));
    rst_n = 1'b1; s_valid_i = 1'b0;
    #1;
    chk("rel_s_ready_low", 32'(s_ready_o), 32'(0));
    step();
    chk("rel_s_ready_high", 32'(s_ready_o), 32'(1));

    // 2: streaming 0x01..0x10
    m_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 8'(i + 1);
      @(negedge clk);
      chk("stream_ready", 32'(s_ready_o), 32'(1));
      step();
      if (i == 0) begin
        chk("lat_not_yet", 32'(m_valid_o), 32'(0));
      end else begin
        chk("stream_valid", 32'(m_valid_o), 32'(1));
        chk("stream_data", 32'(m_data_o), 32'(i));
      end
    end
    s_valid_i = 1'b0;
    step();
    chk("stream_last", 32'(m_data_o), 32'(16));
    step();
    chk("stream_empty", 32'(m_valid_o), 32'(0));
    chk("xfer_wrap", 32'(xfer_cnt_o), 32'(0));

    // 3: backpressure
    m_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid_i = 1'b1;
      s_data_i  = 8'(32'h A0 + idx);
      @(negedge clk);
      acc = s_ready_o;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'(4));
    chk("bp_level", 32'(level_o), 32'(4));
    chk("bp_s_ready", 32'(s_ready_o), 32'(0));
    chk("bp_m_valid", 32'(m_valid_o), 32'(1));
    chk("bp_m_data", 32'(m_data_o), 32'(8'hA0));
    chk("bp_stall", 32'(stall_cnt_o), 32'(4));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stall_inc", 32'(stall_cnt_o), 32'(5 + k));
      chk("bp_hold_data", 32'(m_data_o), 32'(8'hA0));
    end

    // 4: release
    m_ready_i = 1'b1;
    for (int k = 4; k < 8; k++) send(8'(32'h A0 + k));
    drain();
    chk("rel_xfer", 32'(xfer_cnt_o), 32'(8));
    chk("rel_stall", 32'(stall_cnt_o), 32'(7));

    // clear coinciding with a stall, then with a transfer
    m_ready_i = 1'b0;
    send(8'h33);
    repeat (3) step();
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    chk("clr_stall", 32'(stall_cnt_o), 32'(0));
    m_ready_i = 1'b1;
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    chk("clr_xfer", 32'(xfer_cnt_o), 32'(0));
    drain();

    // 5: random valid/ready, 1000 beats
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      if (!s_valid_i && $urandom_range(0, 2) != 0) begin
        s_valid_i = 1'b1;
        s_data_i  = 8'($urandom);
      end
      m_ready_i = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = s_valid_i & s_ready_o;
      step();
      cyc++;
      if (acc) begin
        n++;
        s_valid_i = 1'b0;
      end
    end
    chk("rand_beats", 32'(n), 32'(1000));
    drain();
    chk("stall_sat", 32'(stall_cnt_o), 32'(4'hF));

    // 6: reset mid-stream with three beats held
    m_ready_i = 1'b0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("mid_level", 32'(level_o), 32'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid_o), 32'(0));
    chk("mid_rst_s_ready", 32'(s_ready_o), 32'(0));
    chk("mid_rst_level", 32'(level_o), 32'(0));
    chk("mid_rst_m_data", 32'(m_data_o), 32'(0));
    chk("mid_rst_xfer", 32'(xfer_cnt_o), 32'(0));
    chk("mid_rst_stall", 32'(stall_cnt_o), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_s_ready", 32'(s_ready_o), 32'(1));
    m_ready_i = 1'b1;
    send(8'h55);
    n = 0;
    while (!m_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("post_rst_valid", 32'(m_valid_o), 32'(1));
    chk("post_rst_data", 32'(m_data_o), 32'(8'h55));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
